axi_rd_arbiter: RTL and testbench
=================================

// Module: axi_rd_arbiter
// PURPOSE
//   Two-master AXI4-Lite read-channel arbiter sharing one slave read port (AR+R).
//   Master 0 is the instruction fetch port and master 1 is the load port of core.
//   The shared slave is the memory slave instantiated in top.
//   Exactly one read transaction is in flight; masters alternate round-robin on contention.
//   Write channels are not routed through this block.
// PARAMETERS
//   AW   32   address width, per master and slave
//   DW   32   read data width
// PORTS
//   clk        in   1       clock, all logic on posedge
//   rst        in   1       synchronous reset, active-low (0 = reset)
//   m_arvalid  in   2       per-master AR valid, bit i = master i
//   m_arready  out  2       per-master AR ready
//   m_araddr   in   2*AW    per-master address, master i at [i*AW +: AW]
//   m_rvalid   out  2       per-master R valid
//   m_rready   in   2       per-master R ready
//   m_rdata    out  DW      read data, broadcast to both masters
//   m_rresp    out  2       read response, broadcast to both masters
//   s_arvalid  out  1       slave AR valid
//   s_arready  in   1       slave AR ready
//   s_araddr   out  AW      slave address, registered
//   s_rvalid   in   1       slave R valid
//   s_rready   out  1       slave R ready
//   s_rdata    in   DW      slave read data
//   s_rresp    in   2       slave read response
//   grant      out  1       index of the owning/last-granted master
//   busy       out  1       1 whenever state != IDLE
// BEHAVIOUR
//   Reset (sampled on posedge with rst=0):
//     state=IDLE, last=1, grant=0, addr_q=0, s_arvalid=0, busy=0.
//     Reset mid-transaction aborts to IDLE immediately; the slave is reset by the same rst.
//   FSM IDLE:
//     sel = (both valid) ? ~last : (m_arvalid[1] ? 1 : 0).
//     If any m_arvalid: m_arready[sel]=1 combinationally (other bit 0);
//       addr_q<=m_araddr[sel]; grant<=sel; go ADDR.
//   FSM ADDR:
//     s_arvalid=1, s_araddr=addr_q, addr_q held stable.
//     On s_arready: go DATA. m_arready=0.
//   FSM DATA:
//     m_rvalid[grant]=s_rvalid, s_rready=m_rready[grant].
//     m_rdata=s_rdata, m_rresp=s_rresp (pass-through, resp not interpreted).
//     On s_rvalid&&s_rready: last<=grant; go IDLE.
//   Outside IDLE: m_arready=2'b00. Outside DATA: m_rvalid=2'b00 and s_rready=0.
//   Ungranted master never sees ready/valid asserted.
//   Latency: accept at cycle T -> s_arvalid at T+1. R beat accepted at cycle T -> next accept no earlier than T+1.
//   Minimum 3 cycles per transaction (IDLE, ADDR, DATA).
//   Fairness: a master holding arvalid continuously while the other also requests is served alternately, never twice in a row.
//   Lone requester is granted every time regardless of last.
//   Masters obey AXI: arvalid stays high until arready. Violation may drop the request but the FSM never deadlocks.
//   No timeout: a slave that never asserts arready/rvalid holds the FSM indefinitely.
// TESTING
//   1. Reset: rst=0 for 2 cycles -> s_arvalid=0, m_arready=0, m_rvalid=0, busy=0, grant=0.
//   2. Single read: m0 araddr=0x8000_0000; slave arready on the first ADDR cycle; rvalid 2 cycles later with rdata=0xDEADBEEF
//      -> s_araddr=0x8000_0000 one cycle after the accept; m_rvalid=2'b01; m_rdata=0xDEADBEEF; back to IDLE.
//   3. Simultaneous requests from reset: m0=0x100, m1=0x200 both held -> grant order 0,1,0,1 over 4 transactions.
//      s_araddr sequence 0x100,0x200,0x100,0x200.
//   4. Back-pressure: s_arready low for 5 cycles, then m_rready low for 3 cycles with s_rvalid high
//      -> s_araddr stable throughout; s_rready=0 until m_rready=1; exactly one beat delivered.
//   5. Error pass-through: slave rresp=2'b10 -> m_rresp=2'b10 to the owner only; FSM returns to IDLE normally.
//   6. Reset mid-DATA: rst=0 while s_rvalid=0 in DATA -> next cycle state=IDLE, s_rready=0, last=1.

Source files
------------

// File: rtl/axi_rd_arbiter_if.sv
// Read-channel bundle between two requesting masters, the arbiter and one
// AXI4-Lite memory slave (AR + R channels only).
//   m_*  : per-master side. Bit i of a 2-bit vector belongs to master i, and
//          master i's address sits at m_araddr[i*AW +: AW]. m_rdata and
//          m_rresp are broadcast to both masters.
//   s_*  : shared slave side.
// Modports:
//   arb    : the arbiter itself
//   master : the requesting masters (drive AR, accept R)
//   slave  : the memory slave (accepts AR, drives R)
interface axi_rd_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [1:0]      m_arvalid;
    logic [1:0]      m_arready;
    logic [2*AW-1:0] m_araddr;
    logic [1:0]      m_rvalid;
    logic [1:0]      m_rready;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;

    logic            s_arvalid;
    logic            s_arready;
    logic [AW-1:0]   s_araddr;
    logic            s_rvalid;
    logic            s_rready;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;

    modport arb (
        input  m_arvalid, m_araddr, m_rready,
        input  s_arready, s_rvalid, s_rdata, s_rresp,
        output m_arready, m_rvalid, m_rdata, m_rresp,
        output s_arvalid, s_araddr, s_rready
    );

    modport master (
        output m_arvalid, m_araddr, m_rready,
        input  m_arready, m_rvalid, m_rdata, m_rresp
    );

    modport slave (
        input  s_arvalid, s_araddr, s_rready,
        output s_arready, s_rvalid, s_rdata, s_rresp
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI4-Lite read arbiter sharing one slave read port.
// Master 0 is instruction fetch, master 1 is the load port. One read is in
// flight at a time; on contention the masters alternate round-robin, and a
// lone requester is always granted.
// Ports:
//   clk   : clock, all logic on posedge
//   rst   : synchronous reset, active low
//   bus   : read-channel bundle (arbiter modport)
//   grant : index of the owning / last-granted master
//   busy  : high whenever a transaction is being handled (state != IDLE)
module axi_rd_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                clk,
    input  logic                rst,
    axi_rd_arbiter_if.arb       bus,
    output logic                grant,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_q,  last_d;   // master served by the last completed read
    logic          grant_q, grant_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic          sel;

    // On contention hand the slot to whoever was not served last;
    // otherwise the single requester wins.
    assign sel = (&bus.m_arvalid) ? ~last_q : bus.m_arvalid[1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            grant_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        grant_d       = grant_q;
        addr_d        = addr_q;
        bus.m_arready = 2'b00;
        bus.m_rvalid  = 2'b00;
        bus.s_arvalid = 1'b0;
        bus.s_rready  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|bus.m_arvalid) begin
                    bus.m_arready[sel] = 1'b1;
                    addr_d  = sel ? bus.m_araddr[2*AW-1:AW] : bus.m_araddr[AW-1:0];
                    grant_d = sel;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                bus.s_arvalid = 1'b1;
                if (bus.s_arready) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                // Only the owner is connected to the R handshake; the other
                // master never sees rvalid and its rready is ignored.
                bus.m_rvalid[grant_q] = bus.s_rvalid;
                bus.s_rready          = bus.m_rready[grant_q];
                if (bus.s_rvalid && bus.m_rready[grant_q]) begin
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Address comes straight from the register so it is stable for the
    // whole ADDR phase regardless of what the master does afterwards.
    assign bus.s_araddr = addr_q;
    assign bus.m_rdata  = bus.s_rdata;
    assign bus.m_rresp  = bus.s_rresp;
    assign grant        = grant_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] KEY = 32'h5A5A_C3C3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic grant, busy;

    axi_rd_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    axi_rd_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .grant (grant),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; returns at the following negedge (drive region).
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.m_arvalid = 2'b00;
        bus.m_araddr  = '0;
        bus.m_rready  = 2'b00;
        bus.s_arready = 1'b0;
        bus.s_rvalid  = 1'b0;
        bus.s_rdata   = '0;
        bus.s_rresp   = 2'b00;
    endtask

    // Random-phase reference state (transaction level)
    logic [1:0]    mreq;
    logic [31:0]   maddr [2];
    logic          own_vld, own, ar_sent, last_srv;
    logic [31:0]   oaddr;
    logic          sl_has;
    int            sl_cnt;
    logic [31:0]   sl_data;
    logic [1:0]    sl_resp;
    logic          psel;
    logic [1:0]    exp_ar, exp_rv;
    logic          exp_srr, in_data;
    int            accepts, beats;

    initial begin
        idle_inputs();

        // ---------------- reset ----------------
        rst = 1'b0;
        @(negedge clk);
        cyc();
        #1;
        chk("rst_s_arvalid", bus.s_arvalid, 1'b0);
        chk("rst_m_arready", bus.m_arready, 2'b00);
        chk("rst_m_rvalid",  bus.m_rvalid,  2'b00);
        chk("rst_busy",      busy,          1'b0);
        chk("rst_grant",     grant,         1'b0);
        rst = 1'b1;
        cyc();

        // ---------------- single read, master 0 ----------------
        bus.m_arvalid = 2'b01;
        bus.m_araddr  = {32'h0, 32'h8000_0000};
        #1;
        chk("t2_arready", bus.m_arready, 2'b01);
        chk("t2_busy0",   busy,          1'b0);
        cyc();
        bus.m_arvalid = 2'b00;
        bus.s_arready = 1'b1;
        #1;
        chk("t2_s_arvalid", bus.s_arvalid, 1'b1);
        chk("t2_s_araddr",  bus.s_araddr,  32'h8000_0000);
        chk("t2_grant",     grant,         1'b0);
        chk("t2_arready_addr", bus.m_arready, 2'b00);
        cyc();
        bus.s_arready = 1'b0;
        bus.m_rready  = 2'b11;
        #1;
        chk("t2_rvalid_wait", bus.m_rvalid, 2'b00);
        cyc();
        bus.s_rvalid = 1'b1;
        bus.s_rdata  = 32'hDEAD_BEEF;
        #1;
        chk("t2_m_rvalid", bus.m_rvalid, 2'b01);
        chk("t2_m_rdata",  bus.m_rdata,  32'hDEAD_BEEF);
        cyc();
        bus.s_rvalid = 1'b0;
        #1;
        chk("t2_idle_busy", busy, 1'b0);

        // ---------------- back-pressure, master 1 ----------------
        bus.m_rready  = 2'b00;
        bus.m_arvalid = 2'b10;
        bus.m_araddr  = {32'h300, 32'h0};
        #1;
        chk("t4_arready", bus.m_arready, 2'b10);
        cyc();
        bus.m_arvalid = 2'b00;
        bus.m_araddr  = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_s_arvalid_hold", bus.s_arvalid, 1'b1);
            chk("t4_s_araddr_hold",  bus.s_araddr,  32'h300);
            cyc();
        end
        bus.s_arready = 1'b1;
        #1;
        chk("t4_s_araddr_acc", bus.s_araddr, 32'h300);
        cyc();
        bus.s_arready = 1'b0;
        bus.s_rvalid  = 1'b1;
        bus.s_rdata   = 32'h1234_5678;
        bus.m_rready  = 2'b01;   // only the non-owner is ready
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4_s_rready_stall", bus.s_rready, 1'b0);
            chk("t4_m_rvalid_stall", bus.m_rvalid, 2'b10);
            chk("t4_s_araddr_stall", bus.s_araddr, 32'h300);
            cyc();
        end
        bus.m_rready = 2'b10;
        #1;
        chk("t4_s_rready", bus.s_rready, 1'b1);
        chk("t4_m_rdata",  bus.m_rdata,  32'h1234_5678);
        cyc();
        #1;
        chk("t4_one_beat_rvalid", bus.m_rvalid, 2'b00);
        chk("t4_one_beat_busy",   busy,         1'b0);
        bus.s_rvalid = 1'b0;
        bus.m_rready = 2'b00;

        // ---------------- error response pass-through, master 0 ----------------
        bus.m_arvalid = 2'b01;
        bus.m_araddr  = {32'h0, 32'h44};
        #1;
        chk("t5_arready", bus.m_arready, 2'b01);
        cyc();
        bus.m_arvalid = 2'b00;
        bus.s_arready = 1'b1;
        cyc();
        bus.s_arready = 1'b0;
        bus.s_rvalid  = 1'b1;
        bus.s_rresp   = 2'b10;
        bus.m_rready  = 2'b11;
        #1;
        chk("t5_m_rvalid", bus.m_rvalid, 2'b01);
        chk("t5_m_rresp",  bus.m_rresp,  2'b10);
        chk("t5_s_rready", bus.s_rready, 1'b1);
        cyc();
        bus.s_rvalid = 1'b0;
        bus.s_rresp  = 2'b00;
        #1;
        chk("t5_busy", busy, 1'b0);

        // ---------------- reset in DATA, master 1 owner ----------------
        bus.m_arvalid = 2'b10;
        bus.m_araddr  = {32'h55, 32'h0};
        #1;
        chk("t6_arready", bus.m_arready, 2'b10);
        cyc();
        bus.m_arvalid = 2'b00;
        bus.s_arready = 1'b1;
        cyc();
        bus.s_arready = 1'b0;
        #1;
        chk("t6_busy_data",  busy,          1'b1);
        chk("t6_rready_data", bus.s_rready, 1'b1);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        #1;
        chk("t6_busy",      busy,          1'b0);
        chk("t6_s_rready",  bus.s_rready,  1'b0);
        chk("t6_s_arvalid", bus.s_arvalid, 1'b0);
        chk("t6_grant",     grant,         1'b0);

        // ---------------- contention from reset: 0,1,0,1 ----------------
        bus.m_rready  = 2'b11;
        bus.m_arvalid = 2'b11;
        bus.m_araddr  = {32'h200, 32'h100};
        bus.s_arready = 1'b1;
        bus.s_rvalid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic e;
            e = k[0];
            #1;
            chk("t3_arready", bus.m_arready, 2'b01 << e);
            cyc();
            #1;
            chk("t3_s_araddr", bus.s_araddr, e ? 32'h200 : 32'h100);
            chk("t3_grant",    grant,        e);
            cyc();
            #1;
            chk("t3_m_rvalid", bus.m_rvalid, 2'b01 << e);
            cyc();
        end

        // ---------------- randomized traffic vs reference model ----------------
        idle_inputs();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        mreq = 2'b00; maddr[0] = '0; maddr[1] = '0;
        own_vld = 1'b0; own = 1'b0; ar_sent = 1'b0; last_srv = 1'b1; oaddr = '0;
        sl_has = 1'b0; sl_cnt = 0; sl_data = '0; sl_resp = 2'b00;
        accepts = 0; beats = 0;

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!mreq[i] && $urandom_range(0, 3) == 0) begin
                    mreq[i]  = 1'b1;
                    maddr[i] = $urandom;
                end
            end
            bus.m_arvalid = mreq;
            bus.m_araddr  = {maddr[1], maddr[0]};
            bus.m_rready  = 2'($urandom);
            bus.s_arready = 1'($urandom);
            if (sl_has && sl_cnt > 0) sl_cnt--;
            bus.s_rvalid  = sl_has && (sl_cnt == 0);
            bus.s_rdata   = sl_has ? sl_data : 32'($urandom);
            bus.s_rresp   = sl_resp;
            #1;

            psel    = (&mreq) ? ~last_srv : mreq[1];
            exp_ar  = (!own_vld && |mreq) ? (2'b01 << psel) : 2'b00;
            in_data = own_vld && ar_sent;
            exp_rv  = (in_data && bus.s_rvalid) ? (2'b01 << own) : 2'b00;
            exp_srr = in_data ? bus.m_rready[own] : 1'b0;

            chk("rnd_arready",  bus.m_arready, exp_ar);
            chk("rnd_busy",     busy,          own_vld);
            chk("rnd_s_arvalid", bus.s_arvalid, own_vld && !ar_sent);
            if (own_vld && !ar_sent) chk("rnd_s_araddr", bus.s_araddr, oaddr);
            if (own_vld) chk("rnd_grant", grant, own);
            chk("rnd_m_rvalid", bus.m_rvalid, exp_rv);
            chk("rnd_s_rready", bus.s_rready, exp_srr);
            if (exp_rv != 2'b00) begin
                chk("rnd_m_rdata", bus.m_rdata, oaddr ^ KEY);
                chk("rnd_m_rresp", bus.m_rresp, sl_resp);
            end

            // what the coming edge does
            if (!own_vld && |mreq) begin
                own_vld    = 1'b1;
                own        = psel;
                oaddr      = maddr[psel];
                mreq[psel] = 1'b0;
                ar_sent    = 1'b0;
                accepts++;
            end else if (own_vld && !ar_sent && bus.s_arready) begin
                ar_sent = 1'b1;
                sl_has  = 1'b1;
                sl_cnt  = $urandom_range(0, 3);
                sl_data = bus.s_araddr ^ KEY;
                sl_resp = 2'($urandom);
            end else if (in_data && bus.s_rvalid && bus.m_rready[own]) begin
                last_srv = own;
                own_vld  = 1'b0;
                sl_has   = 1'b0;
                beats++;
            end
            cyc();
        end
        chk("rnd_beat_count", beats + (own_vld ? 1 : 0), accepts);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
